hw_stack: RTL
=============

Name: hw_stack

Overview:
- 16-bit hardware LIFO backing the processor's PUSH/POP instructions, including call/return-data spill.
- Sits directly upstream of the writeback select stage and drives that stage's stack data input (select code 2'b01).
- Popped word is registered, so the writeback stage samples it one cycle after the pop is accepted.
- Reports occupancy, full/empty status and, optionally, sticky overflow/underflow errors.

Parameters:
- DATA_W, 16: stack word width; must match the writeback datapath width.
- ADDR_W, 4: pointer width; DEPTH = 2**ADDR_W entries (16 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- push  input  1  push request, sampled on the rising clk edge.
- pop  input  1  pop request, sampled on the rising clk edge.
- push_data  input  DATA_W  word written on an accepted push.
- err_clr  input  1  clears the sticky error flags (STACK_ERR_EN builds only).
- stack_out  output  DATA_W  last popped word; feeds the writeback select stage.
- sp_count  output  ADDR_W+1  number of valid entries, 0..DEPTH.
- full  output  1  high when sp_count == DEPTH.
- empty  output  1  high when sp_count == 0.
- overflow  output  1  sticky: a push was rejected because the stack was full.
- underflow  output  1  sticky: a pop was rejected because the stack was empty.

Behaviour:
- Reset: clock is single-domain; rst_n is asynchronous assert, synchronous deassert at system level.
  - While rst_n is low: sp <= 0, stack_out <= 0, overflow <= 0, underflow <= 0.
  - Hence empty = 1 and full = 0 during reset.
  - Memory array is not reset; contents are don't-care.
- Storage:
  - mem[0..DEPTH-1] holds the entries; sp is the entry count.
  - Top of stack is mem[sp-1].
  - full, empty and sp_count are combinational decodes of the sp register, with no extra latency.
- Operations, decided on each rising edge from {push, pop} and the current sp:
  - Push only, not full: mem[sp] <= push_data; sp <= sp+1. stack_out unchanged.
  - Push only, full: rejected. mem and sp unchanged; overflow <= 1.
  - Pop only, not empty: stack_out <= mem[sp-1]; sp <= sp-1. The word is visible on stack_out the cycle after the edge (1-cycle latency).
  - Pop only, empty: rejected. sp and stack_out hold; underflow <= 1.
  - Push and pop, not empty (including full): replace-top. stack_out <= mem[sp-1]; mem[sp-1] <= push_data; sp unchanged; no error.
  - Push and pop, empty: bypass. stack_out <= push_data; sp stays 0; no error.
  - Idle (neither asserted): all state holds.
- stack_out is held between pops; only an accepted pop or a bypass changes it.
- Wrap-around: sp never wraps. It saturates at DEPTH on push and at 0 on pop by rejection, never by modulo arithmetic.
- Error clear:
  - err_clr clears both sticky flags on the edge.
  - If a new rejected op occurs on the same edge, the new error wins and the flag ends high.
- Reset mid-operation: an asserted rst_n overrides any in-flight push/pop immediately. No partial write is guaranteed to take effect.

Optional Feature:
- Macro: STACK_ERR_EN.
- Defined:
  - overflow/underflow are sticky registers as described above.
  - err_clr is functional.
- Undefined:
  - overflow and underflow are tied to 0.
  - err_clr is ignored.
  - Rejection of illegal push/pop and saturation of sp are unchanged.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> sp_count = 3, empty = 0, stack_out = 0x0000.
- Pop three times -> stack_out = 0x3333, 0x2222, 0x1111, each one cycle after its pop edge; sp_count ends at 0; empty = 1.
- Push 16 words 0x0000..0x000F, then push 0xDEAD -> full = 1, sp_count = 16, overflow = 1 (STACK_ERR_EN). Subsequent pop returns 0x000F, not 0xDEAD.
- With stack empty, pop -> stack_out holds its previous value, underflow = 1. Then err_clr -> underflow = 0. err_clr on the same edge as an empty pop -> underflow stays 1.
- Push 0xAAAA, then push+pop with push_data = 0xBBBB -> stack_out = 0xAAAA, sp_count = 1. Next pop -> 0xBBBB. Push+pop on empty with 0xCCCC -> stack_out = 0xCCCC, sp_count = 0.
- Assert rst_n low asynchronously mid-push with sp_count = 5 -> sp_count = 0, stack_out = 0, flags = 0 before the next clk edge.

Source files
------------

// File: rtl/hw_stack.sv
// hw_stack: 16-bit hardware LIFO behind the PUSH/POP instructions.
// The popped word is registered. It feeds writeback select code 2'b01.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   push       push request
//   pop        pop request
//   push_data  word written on an accepted push or replace-top
//   err_clr    clears the sticky error flags (STACK_ERR_EN builds only)
//   stack_out  last popped (or bypassed) word
//   sp_count   number of valid entries, 0..DEPTH
//   full       sp_count == DEPTH
//   empty      sp_count == 0
//   overflow   sticky: a push was rejected while full
//   underflow  sticky: a pop was rejected while empty
//
// Build option: define STACK_ERR_EN for sticky overflow/underflow flags.
// When it is undefined, both flags are tied low and err_clr is ignored.
// Illegal operations are still rejected.
module hw_stack #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] stack_out,
    output logic [ADDR_W:0]   sp_count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   sp;
    logic [ADDR_W-1:0] top_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              do_push;
    logic              do_pop;
    logic              do_replace;
    logic              do_bypass;
    logic              wr_en;

    assign sp_count = sp;
    assign full     = (sp == (ADDR_W+1)'(DEPTH));
    assign empty    = (sp == '0);

    // When sp == DEPTH the low bits are zero, so the subtraction wraps to
    // DEPTH-1. That is the correct top index.
    assign top_idx    = sp[ADDR_W-1:0] - ADDR_W'(1);

    assign do_push    = push & ~pop & ~full;
    assign do_pop     = pop & ~push & ~empty;
    assign do_replace = push & pop & ~empty;
    assign do_bypass  = push & pop & empty;

    assign wr_en  = do_push | do_replace;
    assign wr_idx = do_replace ? top_idx : sp[ADDR_W-1:0];

    // The storage array is not reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp        <= '0;
            stack_out <= '0;
        end else begin
            if (do_push) begin
                sp <= sp + (ADDR_W+1)'(1);
            end else if (do_pop) begin
                sp <= sp - (ADDR_W+1)'(1);
            end

            // Replace-top reads the old top here while the same edge overwrites it.
            if (do_pop || do_replace) begin
                stack_out <= mem[top_idx];
            end else if (do_bypass) begin
                stack_out <= push_data;
            end
        end
    end

`ifdef STACK_ERR_EN
    logic rej_push;
    logic rej_pop;

    assign rej_push = push & ~pop & full;
    assign rej_pop  = pop & ~push & empty;

    // A rejection on the same edge as err_clr leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rej_push) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end

            if (rej_pop) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule
